// File: rtl/psk_symbol_serializer_pkg.sv
// Shared definitions for the PSK symbol serializer: FSM state encoding and
// the helpers that size the per-sample symbol counter.
package psk_defs;

  // Controller states. Only IDLE and RUN are legal; any other encoding
  // that appears on the state register is steered back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } psk_state_e;

  // Number of k-bit symbols carried by one FIFO sample.
  function automatic int sym_per_sample(input int sample_width,
                                        input int bits_per_symbol);
    return sample_width / bits_per_symbol;
  endfunction

  // Width of a counter that must hold 0..n-1. This is never narrower than
  // one bit, so a single-symbol sample still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psk_symbol_serializer_phase_map.sv
// Symbol-to-phase mapper. It optionally Gray-encodes the symbol and then
// optionally accumulates it modulo 2^k for differential PSK. The phase
// register changes only when i_acc_en is high, which happens on the edge
// that starts a symbol.
module psk_phase_map
  import psk_defs::*;
#(
  parameter int BITS_PER_SYMBOL = 2,
  parameter int GRAY            = 0,
  parameter int DIFFERENTIAL    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_acc_en,
  input  logic [BITS_PER_SYMBOL-1:0] i_symbol,
  output logic [BITS_PER_SYMBOL-1:0] o_phase
);

  logic [BITS_PER_SYMBOL-1:0] w_gray;
  logic [BITS_PER_SYMBOL-1:0] w_mapped;
  logic [BITS_PER_SYMBOL-1:0] w_acc_next;
  logic [BITS_PER_SYMBOL-1:0] r_acc;
  logic [BITS_PER_SYMBOL-1:0] r_phase;

  // Gray-encode first, then add to the running sum. The sum wraps
  // naturally because it is exactly k bits wide.
  always_comb begin
    w_gray     = i_symbol ^ (i_symbol >> 1);
    w_mapped   = (GRAY != 0) ? w_gray : i_symbol;
    w_acc_next = r_acc + w_mapped;
  end

  // Update the phase and the accumulator only on a symbol-start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (i_acc_en) begin
      r_acc   <= w_acc_next;
      r_phase <= (DIFFERENTIAL != 0) ? w_acc_next : w_mapped;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/psk_symbol_serializer.sv
// PSK symbol serializer. It pops samples from a show-ahead FIFO, slices each
// sample into k-bit symbols, and holds each symbol for clks_per_symbol clocks
// while it drives a phase index to the carrier stage.
//
// FIFO handshake: 'sample' is valid whenever 'empty' is low. 'read' is a
// combinational pop that is high only in a cycle where this block also
// captures 'sample' on the closing clock edge. The FIFO must therefore treat
// read as "consumed at this edge", and it is never asserted while empty is
// high, while enable is low, or while rst is high.
module psk_symbol_serializer
  import psk_defs::*;
#(
  parameter int SAMPLE_WIDTH    = 8,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int CPS_WIDTH       = 8,
  parameter int MSB_FIRST       = 0,
  parameter int DIFFERENTIAL    = 0,
  parameter int GRAY            = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [CPS_WIDTH-1:0]       clks_per_symbol,
  input  logic [SAMPLE_WIDTH-1:0]    sample,
  input  logic                       empty,
  output logic                       read,
  output logic [BITS_PER_SYMBOL-1:0] phase,
  output logic                       symb_strobe,
  output logic                       nsync,
  output logic                       underrun,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int SYMS  = sym_per_sample(SAMPLE_WIDTH, BITS_PER_SYMBOL);
  localparam int SYM_W = cnt_width(SYMS);
  localparam logic [SYM_W-1:0]     LAST_SYM = SYM_W'(SYMS - 1);
  localparam logic [CPS_WIDTH-1:0] CPS_ONE  = CPS_WIDTH'(1);

  psk_state_e                 r_state;
  psk_state_e                 w_state_next;
  logic [SAMPLE_WIDTH-1:0]    r_sample;
  logic [SAMPLE_WIDTH-1:0]    w_shifted;
  logic [CPS_WIDTH-1:0]       r_clk_cnt;
  logic [CPS_WIDTH-1:0]       r_cps;
  logic [CPS_WIDTH-1:0]       w_cps_in;
  logic [SYM_W-1:0]           r_sym_cnt;
  logic                       r_strobe;
  logic                       r_nsync;
  logic                       w_go;
  logic                       w_last_clk;
  logic                       w_last_sym;
  logic                       w_capture;
  logic                       w_shift;
  logic                       w_stop;
  logic [BITS_PER_SYMBOL-1:0] w_symbol;

  // Derived timing terms. A zero clocks-per-symbol value is treated as one.
  // The sample register is shifted toward the end from which symbols are
  // taken, so the next symbol always sits at that end.
  always_comb begin
    w_go       = enable & ~rst;
    w_cps_in   = (clks_per_symbol == '0) ? CPS_ONE : clks_per_symbol;
    w_last_clk = (r_clk_cnt == (r_cps - CPS_ONE));
    w_last_sym = (r_sym_cnt == LAST_SYM);
    if (MSB_FIRST != 0) begin
      w_shifted = r_sample << BITS_PER_SYMBOL;
    end else begin
      w_shifted = r_sample >> BITS_PER_SYMBOL;
    end
  end

  // Symbol for the edge that starts a symbol. On a capture it comes from the
  // incoming FIFO word. On a shift it comes from the shifted sample register.
  always_comb begin
    if (MSB_FIRST != 0) begin
      w_symbol = w_capture ? sample[SAMPLE_WIDTH-1 -: BITS_PER_SYMBOL]
                           : w_shifted[SAMPLE_WIDTH-1 -: BITS_PER_SYMBOL];
    end else begin
      w_symbol = w_capture ? sample[BITS_PER_SYMBOL-1:0]
                           : w_shifted[BITS_PER_SYMBOL-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic and the combinational pop and underrun strobes.
  // At the end of the last symbol of a sample, the next sample is captured
  // on the same edge when one is available, so no gap cycle is inserted.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_shift      = 1'b0;
    w_stop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go && !empty) begin
          w_capture    = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_go && w_last_clk) begin
          if (!w_last_sym) begin
            w_shift = 1'b1;
          end else if (!empty) begin
            w_capture = 1'b1;
          end else begin
            w_stop       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    read     = w_capture;
    underrun = w_stop;
  end

  // Datapath: sample register, counters, the latched clocks-per-symbol value,
  // and the registered strobe and nsync flags. The cps value is latched only
  // on an edge that starts a symbol, so a mid-symbol change waits for the
  // next symbol. While enable is low, every register holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample  <= '0;
      r_clk_cnt <= '0;
      r_sym_cnt <= '0;
      r_cps     <= '0;
      r_strobe  <= 1'b0;
      r_nsync   <= 1'b1;
    end else if (w_capture) begin
      r_sample  <= sample;
      r_clk_cnt <= '0;
      r_sym_cnt <= '0;
      r_cps     <= w_cps_in;
      r_strobe  <= 1'b1;
      r_nsync   <= 1'b0;
    end else if (w_shift) begin
      r_sample  <= w_shifted;
      r_clk_cnt <= '0;
      r_sym_cnt <= r_sym_cnt + 1'b1;
      r_cps     <= w_cps_in;
      r_strobe  <= 1'b1;
      r_nsync   <= 1'b1;
    end else if (w_stop) begin
      r_clk_cnt <= '0;
      r_sym_cnt <= '0;
      r_strobe  <= 1'b0;
      r_nsync   <= 1'b1;
    end else if (enable && (r_state == ST_RUN)) begin
      r_clk_cnt <= r_clk_cnt + CPS_ONE;
      r_strobe  <= 1'b0;
    end else if (enable) begin
      r_strobe  <= 1'b0;
    end
  end

  psk_phase_map #(
    .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
    .GRAY            (GRAY),
    .DIFFERENTIAL    (DIFFERENTIAL)
  ) u_phase_map (
    .clk      (clk),
    .rst      (rst),
    .i_acc_en (w_capture | w_shift),
    .i_symbol (w_symbol),
    .o_phase  (phase)
  );

  // When enable is low, the strobe is masked and its register is frozen.
  // The strobe therefore marks the first enabled cycle of each symbol.
  assign symb_strobe = r_strobe & enable;
  assign nsync       = r_nsync;
  assign busy        = (r_state == ST_RUN);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_psk_symbol_serializer.sv
// Directed bench for psk_symbol_serializer. It uses four instances, one per
// parameter set:
//   a: LSB-first, absolute phase
//   b: MSB-first, differential
//   c: Gray coding
//   d: 1-bit samples and symbols
// Inputs change 1 ns after each rising edge. Outputs are sampled on the
// falling edge.
module tb_psk_symbol_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Instance a: defaults.
  logic       en_a, emp_a, rd_a, stb_a, ns_a, ur_a, bz_a;
  logic [7:0] cps_a, smp_a;
  logic [1:0] ph_a, st_a;
  // Instance b: MSB-first, differential.
  logic       en_b, emp_b, rd_b, stb_b, ns_b, ur_b, bz_b;
  logic [7:0] cps_b, smp_b;
  logic [1:0] ph_b, st_b;
  // Instance c: Gray coding.
  logic       en_c, emp_c, rd_c, stb_c, ns_c, ur_c, bz_c;
  logic [7:0] cps_c, smp_c;
  logic [1:0] ph_c, st_c;
  // Instance d: k=1, width 1.
  logic       en_d, emp_d, rd_d, stb_d, ns_d, ur_d, bz_d;
  logic [7:0] cps_d;
  logic [0:0] smp_d, ph_d;
  logic [1:0] st_d;

  psk_symbol_serializer u_dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .clks_per_symbol(cps_a),
    .sample(smp_a), .empty(emp_a), .read(rd_a), .phase(ph_a),
    .symb_strobe(stb_a), .nsync(ns_a), .underrun(ur_a), .busy(bz_a),
    .dbg_state(st_a));

  psk_symbol_serializer #(.MSB_FIRST(1), .DIFFERENTIAL(1)) u_dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .clks_per_symbol(cps_b),
    .sample(smp_b), .empty(emp_b), .read(rd_b), .phase(ph_b),
    .symb_strobe(stb_b), .nsync(ns_b), .underrun(ur_b), .busy(bz_b),
    .dbg_state(st_b));

  psk_symbol_serializer #(.GRAY(1)) u_dut_c (
    .clk(clk), .rst(rst), .enable(en_c), .clks_per_symbol(cps_c),
    .sample(smp_c), .empty(emp_c), .read(rd_c), .phase(ph_c),
    .symb_strobe(stb_c), .nsync(ns_c), .underrun(ur_c), .busy(bz_c),
    .dbg_state(st_c));

  psk_symbol_serializer #(.SAMPLE_WIDTH(1), .BITS_PER_SYMBOL(1)) u_dut_d (
    .clk(clk), .rst(rst), .enable(en_d), .clks_per_symbol(cps_d),
    .sample(smp_d), .empty(emp_d), .read(rd_d), .phase(ph_d),
    .symb_strobe(stb_d), .nsync(ns_d), .underrun(ur_d), .busy(bz_d),
    .dbg_state(st_d));

  // Advance to just after the next rising edge. This is where inputs change.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_a = 1'b1; emp_a = 1'b0; smp_a = 8'hE4; cps_a = 8'd4;
    en_b = 1'b1; emp_b = 1'b0; smp_b = 8'h55; cps_b = 8'd1;
    en_c = 1'b1; emp_c = 1'b0; smp_c = 8'h4E; cps_c = 8'd1;
    en_d = 1'b1; emp_d = 1'b0; smp_d = 1'b1;  cps_d = 8'd0;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if ({ph_a, stb_a, ns_a, ur_a, rd_a, bz_a, st_a} !== 9'b00_0_1_0_0_0_00) begin
      failures++;
      $display("FAIL reset_a got=%b exp=%b",
               {ph_a, stb_a, ns_a, ur_a, rd_a, bz_a, st_a}, 9'b00_0_1_0_0_0_00);
    end
    checks++;
    if ({rd_b, rd_c, rd_d, bz_b, bz_c, bz_d} !== 6'b0) begin
      failures++;
      $display("FAIL reset_read_busy_bcd got=%b exp=000000",
               {rd_b, rd_c, rd_d, bz_b, bz_c, bz_d});
    end
    checks++;
    if ({ns_b, ns_c, ns_d, ph_b, ph_c, ph_d} !== 8'b111_00_00_0) begin
      failures++;
      $display("FAIL reset_nsync_phase_bcd got=%b exp=11100000",
               {ns_b, ns_c, ns_d, ph_b, ph_c, ph_d});
    end
    cyc();
    rst = 1'b0;
    emp_a = 1'b1; emp_b = 1'b1; emp_c = 1'b1; emp_d = 1'b1;
  endtask

  // 0xE4, LSB-first, absolute phase, cps=4: phases 0,1,2,3 for four cycles each.
  task automatic test_lsb_abs();
    logic [6:0] exp_v;
    cyc();
    emp_a = 1'b0; smp_a = 8'hE4; cps_a = 8'd4; en_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_a, bz_a} !== 2'b10) begin
      failures++;
      $display("FAIL lsb_capture read_busy got=%b exp=10", {rd_a, bz_a});
    end
    for (int i = 0; i < 16; i++) begin
      cyc();
      emp_a = 1'b1;
      @(negedge clk);
      exp_v = {2'(i / 4), (i % 4 == 0), (i >= 4), (i == 15), 1'b0, 1'b1};
      checks++;
      if ({ph_a, stb_a, ns_a, ur_a, rd_a, bz_a} !== exp_v) begin
        failures++;
        $display("FAIL lsb_cycle %0d {phase,strobe,nsync,underrun,read,busy} got=%b exp=%b",
                 i, {ph_a, stb_a, ns_a, ur_a, rd_a, bz_a}, exp_v);
      end
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({ph_a, bz_a, ur_a, stb_a} !== 5'b11_0_0_0) begin
      failures++;
      $display("FAIL lsb_idle_hold {phase,busy,underrun,strobe} got=%b exp=11000",
               {ph_a, bz_a, ur_a, stb_a});
    end
  endtask

  // 0x55 twice, MSB-first, differential, cps=1: phases 1,2,3,0,1,2,3,0 with no gap.
  task automatic test_back_to_back();
    int         exp_ph [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [6:0] exp_v;
    cyc();
    emp_b = 1'b0; smp_b = 8'h55; cps_b = 8'd1;
    @(negedge clk);
    checks++;
    if (rd_b !== 1'b1) begin
      failures++;
      $display("FAIL b2b_read cycle 0 got=%b exp=1", rd_b);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      emp_b = (i <= 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp_v = {2'(exp_ph[i-1]), 1'b1, !(i == 1 || i == 5), (i == 8), (i == 4), 1'b1};
      checks++;
      if ({ph_b, stb_b, ns_b, ur_b, rd_b, bz_b} !== exp_v) begin
        failures++;
        $display("FAIL b2b_cycle %0d {phase,strobe,nsync,underrun,read,busy} got=%b exp=%b",
                 i, {ph_b, stb_b, ns_b, ur_b, rd_b, bz_b}, exp_v);
      end
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bz_b !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle busy got=%b exp=0", bz_b);
    end
  endtask

  // 0x4E carries LSB-first symbols 2,3,0,1; the Gray-coded phases are 3,2,0,1.
  task automatic test_gray();
    int exp_ph [4] = '{3, 2, 0, 1};
    cyc();
    emp_c = 1'b0; smp_c = 8'h4E; cps_c = 8'd1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cyc();
      emp_c = 1'b1;
      @(negedge clk);
      checks++;
      if ({ph_c, ur_c} !== {2'(exp_ph[i]), (i == 3)}) begin
        failures++;
        $display("FAIL gray_symbol %0d {phase,underrun} got=%b exp=%b",
                 i, {ph_c, ur_c}, {2'(exp_ph[i]), (i == 3)});
      end
    end
  endtask

  // k=1, width 1, cps=0: one pop and one strobe on every cycle while data lasts.
  task automatic test_one_bit();
    logic       bits [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] exp_v;
    cyc();
    emp_d = 1'b0; smp_d = bits[0]; cps_d = 8'd0;
    @(negedge clk);
    checks++;
    if (rd_d !== 1'b1) begin
      failures++;
      $display("FAIL onebit_read cycle 0 got=%b exp=1", rd_d);
    end
    for (int j = 1; j <= 5; j++) begin
      cyc();
      if (j < 5) begin
        emp_d = 1'b0;
        smp_d = bits[j];
      end else begin
        emp_d = 1'b1;
      end
      @(negedge clk);
      exp_v = {bits[j-1], 1'b1, 1'b0, (j == 5), (j < 5)};
      checks++;
      if ({ph_d, stb_d, ns_d, ur_d, rd_d} !== exp_v) begin
        failures++;
        $display("FAIL onebit_cycle %0d {phase,strobe,nsync,underrun,read} got=%b exp=%b",
                 j, {ph_d, stb_d, ns_d, ur_d, rd_d}, exp_v);
      end
    end
  endtask

  // Check that enable low stretches a symbol, that a cps change applies at
  // the next symbol, and that a mid-symbol reset clears the block.
  task automatic test_hold_and_reset();
    logic       en_pat  [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int         exp_ph  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2};
    logic       exp_stb [10] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    logic [4:0] exp_v;
    cyc();
    en_a = 1'b1; emp_a = 1'b0; smp_a = 8'hE4; cps_a = 8'd4;
    @(negedge clk);
    checks++;
    if (rd_a !== 1'b1) begin
      failures++;
      $display("FAIL hold_capture read got=%b exp=1", rd_a);
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      en_a  = en_pat[i];
      emp_a = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      if (i == 5) cps_a = 8'd2;
      @(negedge clk);
      exp_v = {2'(exp_ph[i]), exp_stb[i], 1'b0, 1'b0};
      checks++;
      if ({ph_a, stb_a, rd_a, ur_a} !== exp_v) begin
        failures++;
        $display("FAIL hold_cycle %0d {phase,strobe,read,underrun} got=%b exp=%b",
                 i, {ph_a, stb_a, rd_a, ur_a}, exp_v);
      end
    end
    cyc();
    rst = 1'b1; emp_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_a, ur_a} !== 2'b00) begin
      failures++;
      $display("FAIL reset_midsym read_underrun got=%b exp=00", {rd_a, ur_a});
    end
    cyc();
    rst = 1'b0; en_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({ph_a, bz_a, ns_a, stb_a, rd_a, st_a} !== 8'b00_0_1_0_0_00) begin
      failures++;
      $display("FAIL reset_midsym_after {phase,busy,nsync,strobe,read,state} got=%b exp=00010000",
               {ph_a, bz_a, ns_a, stb_a, rd_a, st_a});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lsb_abs();
    test_back_to_back();
    test_gray();
    test_one_bit();
    test_hold_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
